// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;
   localparam int XLEN_DEF    = 32;
   localparam int PC_STEP_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2,
      KILL = 2'd3
   } fetch_state_e;
endpackage

// File: rtl/fetch_perf_ctr.sv
// Hand-off and stall-cycle event counters for the fetch stage; both wrap silently.
import fetch_pkg::*;

module fetch_perf_ctr #(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             handoff_i,
   input  logic             stall_hit_i,
   output logic [CNT_W-1:0] fetch_cnt_o,
   output logic [CNT_W-1:0] stall_cnt_o
);
   logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (handoff_i)   fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
      if (stall_hit_i) stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign fetch_cnt_o = fetch_cnt_q;
   assign stall_cnt_o = stall_cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, imem request/ack, {pc+step, inst} to IF/ID; request-to-valid = mem latency + 1.
// Holds output under stall, flush redirects; FETCH_PERF_EN adds hand-off/stall counters.
import fetch_pkg::*;

module fetch_unit #(
   parameter int              XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              PC_STEP  = PC_STEP_DEF
`ifdef FETCH_PERF_EN
   ,
   parameter int              CNT_W    = 32
`endif
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            start_i,
   input  logic            stall_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] target_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ack_i,
   input  logic [XLEN-1:0] imem_data_i,
   output logic            inst_valid_o,
   output logic [XLEN-1:0] inst_o,
   output logic [XLEN-1:0] add_pc_o
`ifdef FETCH_PERF_EN
   ,
   output logic [CNT_W-1:0] perf_fetch_cnt_o,
   output logic [CNT_W-1:0] perf_stall_cnt_o
`endif
);
   localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] inst_q, inst_d;
   logic [XLEN-1:0] add_pc_q, add_pc_d;
   logic            valid_q, valid_d;
   logic            req_q, req_d;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      inst_d   = inst_q;
      add_pc_d = add_pc_q;
      valid_d  = valid_q;
      case (state_q)
         IDLE: begin
            if (flush_i)      pc_d    = target_i;
            else if (start_i) state_d = REQ;
         end
         REQ: begin
            // An ack arriving with the flush completes the old request, so no kill is needed.
            if (flush_i) begin
               pc_d    = target_i;
               state_d = imem_ack_i ? REQ : KILL;
            end else if (imem_ack_i) begin
               inst_d   = imem_data_i;
               add_pc_d = pc_q + STEP;
               valid_d  = 1'b1;
               pc_d     = pc_q + STEP;
               state_d  = HOLD;
            end
         end
         HOLD: begin
            if (flush_i) begin
               pc_d    = target_i;
               state_d = REQ;
            end else if (!stall_i) begin
               valid_d = 1'b0;
               state_d = REQ;
            end
         end
         KILL: begin
            // Redirects keep landing in pc; leave only once the orphaned ack has drained.
            if (flush_i)    pc_d    = target_i;
            if (imem_ack_i) state_d = REQ;
         end
         default: state_d = IDLE;
      endcase
      if (flush_i) valid_d = 1'b0;
      req_d = (state_d == REQ);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         inst_q   <= '0;
         add_pc_q <= '0;
         valid_q  <= 1'b0;
         req_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         inst_q   <= inst_d;
         add_pc_q <= add_pc_d;
         valid_q  <= valid_d;
         req_q    <= req_d;
      end
   end

   assign imem_req_o   = req_q;
   assign imem_addr_o  = pc_q;
   assign inst_valid_o = valid_q;
   assign inst_o       = inst_q;
   assign add_pc_o     = add_pc_q;

`ifdef FETCH_PERF_EN
   fetch_perf_ctr #(
      .CNT_W(CNT_W)
   ) u_perf (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .handoff_i  (valid_q & ~stall_i & ~flush_i),
      .stall_hit_i(valid_q & stall_i),
      .fetch_cnt_o(perf_fetch_cnt_o),
      .stall_cnt_o(perf_stall_cnt_o)
   );
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector table, hand sequences and a randomized run against a transaction-level fetch model.
module tb_fetch_unit;
   logic        clk;
   logic        rst_n;
   logic        start_i, stall_i, flush_i, imem_ack_i;
   logic [31:0] target_i, imem_data_i;
   logic        imem_req_o, inst_valid_o;
   logic [31:0] imem_addr_o, inst_o, add_pc_o;

   logic        b_start, b_stall, b_flush, b_ack;
   logic [31:0] b_target, b_data;
   logic        b_req, b_valid;
   logic [31:0] b_addr, b_inst, b_add_pc;

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch, perf_stall, b_perf_fetch, b_perf_stall;
`endif

   int checks = 0;
   int errors = 0;

   fetch_unit dut (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start_i), .stall_i(stall_i), .flush_i(flush_i),
      .target_i(target_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
      .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i), .inst_valid_o(inst_valid_o),
      .inst_o(inst_o), .add_pc_o(add_pc_o)
`ifdef FETCH_PERF_EN
      , .perf_fetch_cnt_o(perf_fetch), .perf_stall_cnt_o(perf_stall)
`endif
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(b_start), .stall_i(b_stall), .flush_i(b_flush),
      .target_i(b_target), .imem_req_o(b_req), .imem_addr_o(b_addr),
      .imem_ack_i(b_ack), .imem_data_i(b_data), .inst_valid_o(b_valid),
      .inst_o(b_inst), .add_pc_o(b_add_pc)
`ifdef FETCH_PERF_EN
      , .perf_fetch_cnt_o(b_perf_fetch), .perf_stall_cnt_o(b_perf_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        start, stall, flush, ack;
      logic [31:0] target, data;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_inst, e_addpc;
   } vec_t;

   function automatic vec_t mk(input logic st, input logic sl, input logic fl, input logic [31:0] tg,
                               input logic ak, input logic [31:0] dt, input logic er,
                               input logic [31:0] ea, input logic ev, input logic [31:0] ei,
                               input logic [31:0] ep);
      vec_t v;
      v.start = st; v.stall = sl; v.flush = fl; v.target = tg; v.ack = ak; v.data = dt;
      v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_inst = ei; v.e_addpc = ep;
      return v;
   endfunction

   vec_t tbl [0:21];

   // Reference model state: next fetch PC, held instruction, orphaned-request flag.
   logic [31:0] m_pc, m_inst, m_pc4;
   logic        m_held, m_kill, exp_req;
   int          m_fetches, m_stalls;
   logic        pend;
   int          wcnt;

   initial begin
      tbl[0]  = mk(1,0,0,0,    0,0,    0,32'h000,0,0,0);
      tbl[1]  = mk(0,0,0,0,    0,0,    1,32'h000,0,0,0);
      tbl[2]  = mk(0,0,0,0,    1,32'hA0, 1,32'h000,0,0,0);
      tbl[3]  = mk(0,0,0,0,    0,0,    0,32'h004,1,32'hA0,32'h004);
      tbl[4]  = mk(0,0,0,0,    0,0,    1,32'h004,0,0,0);
      tbl[5]  = mk(0,0,0,0,    1,32'hA1, 1,32'h004,0,0,0);
      tbl[6]  = mk(0,1,0,0,    0,0,    0,32'h008,1,32'hA1,32'h008);
      tbl[7]  = mk(0,1,0,0,    0,0,    0,32'h008,1,32'hA1,32'h008);
      tbl[8]  = mk(0,1,0,0,    0,0,    0,32'h008,1,32'hA1,32'h008);
      tbl[9]  = mk(0,0,0,0,    0,0,    0,32'h008,1,32'hA1,32'h008);
      tbl[10] = mk(0,0,0,0,    0,0,    1,32'h008,0,0,0);
      tbl[11] = mk(0,0,0,0,    1,32'hA2, 1,32'h008,0,0,0);
      tbl[12] = mk(0,0,0,0,    0,0,    0,32'h00C,1,32'hA2,32'h00C);
      tbl[13] = mk(0,0,1,32'h100,0,0,  1,32'h00C,0,0,0);
      tbl[14] = mk(0,0,0,0,    0,0,    0,32'h100,0,0,0);
      tbl[15] = mk(0,0,0,0,    1,32'hDEAD, 0,32'h100,0,0,0);
      tbl[16] = mk(0,0,0,0,    0,0,    1,32'h100,0,0,0);
      tbl[17] = mk(0,1,1,32'h200,1,32'hB0, 1,32'h100,0,0,0);
      tbl[18] = mk(0,0,0,0,    0,0,    1,32'h200,0,0,0);
      tbl[19] = mk(0,0,0,0,    1,32'hB1, 1,32'h200,0,0,0);
      tbl[20] = mk(0,1,1,32'h300,0,0,  0,32'h204,1,32'hB1,32'h204);
      tbl[21] = mk(0,0,0,0,    0,0,    1,32'h300,0,0,0);

      rst_n = 1'b0;
      start_i = 0; stall_i = 0; flush_i = 0; imem_ack_i = 0; target_i = 0; imem_data_i = 0;
      b_start = 0; b_stall = 0; b_flush = 0; b_ack = 0; b_target = 0; b_data = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         chk($sformatf("v%0d_req", i), {31'd0, imem_req_o}, {31'd0, tbl[i].e_req});
         chk($sformatf("v%0d_addr", i), imem_addr_o, tbl[i].e_addr);
         chk($sformatf("v%0d_valid", i), {31'd0, inst_valid_o}, {31'd0, tbl[i].e_valid});
         if (tbl[i].e_valid || i == 0) begin
            chk($sformatf("v%0d_inst", i), inst_o, tbl[i].e_inst);
            chk($sformatf("v%0d_addpc", i), add_pc_o, tbl[i].e_addpc);
         end
         start_i = tbl[i].start; stall_i = tbl[i].stall; flush_i = tbl[i].flush;
         target_i = tbl[i].target; imem_ack_i = tbl[i].ack; imem_data_i = tbl[i].data;
      end
      @(negedge clk);
      start_i = 0; stall_i = 0; flush_i = 0; imem_ack_i = 0;

      // Reset while a request is outstanding, then a stale ack once released.
      rst_n = 1'b0;
      #1;
      chk("rst_req", {31'd0, imem_req_o}, 32'd0);
      chk("rst_addr", imem_addr_o, 32'd0);
      chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      imem_ack_i = 1; imem_data_i = 32'h57A1E;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         imem_ack_i = 0;
         chk($sformatf("stale%0d_req", k), {31'd0, imem_req_o}, 32'd0);
         chk($sformatf("stale%0d_valid", k), {31'd0, inst_valid_o}, 32'd0);
         chk($sformatf("stale%0d_addr", k), imem_addr_o, 32'd0);
      end
      start_i = 1;
      @(negedge clk);
      start_i = 0;
      chk("restart_req", {31'd0, imem_req_o}, 32'd1);
      chk("restart_addr", imem_addr_o, 32'd0);

      // PC wrap on the instance reset to the top word.
      chk("wrap_addr0", b_addr, 32'hFFFF_FFFC);
      b_start = 1;
      @(negedge clk);
      b_start = 0;
      chk("wrap_req0", {31'd0, b_req}, 32'd1);
      chk("wrap_addr1", b_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      b_ack = 1; b_data = 32'hC0;
      @(negedge clk);
      b_ack = 0;
      chk("wrap_valid", {31'd0, b_valid}, 32'd1);
      chk("wrap_inst", b_inst, 32'hC0);
      chk("wrap_addpc", b_add_pc, 32'h0);
      @(negedge clk);
      chk("wrap_req1", {31'd0, b_req}, 32'd1);
      chk("wrap_addr2", b_addr, 32'h0);

      // Randomized run: stall, flush and memory latency all vary.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_i = 1;
      m_pc = 32'd0; m_held = 0; m_kill = 0; m_fetches = 0; m_stalls = 0;
      pend = 0; wcnt = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         start_i = 0;
         exp_req = !m_kill && !m_held;
         chk("rnd_valid", {31'd0, inst_valid_o}, {31'd0, m_held});
         if (m_held) begin
            chk("rnd_inst", inst_o, m_inst);
            chk("rnd_addpc", add_pc_o, m_pc4);
         end
         chk("rnd_req", {31'd0, imem_req_o}, {31'd0, exp_req});
         if (exp_req) chk("rnd_addr", imem_addr_o, m_pc);

         imem_ack_i = 0; imem_data_i = 0;
         if (pend) begin
            wcnt--;
            if (wcnt == 0) begin
               imem_ack_i = 1; imem_data_i = $urandom; pend = 0;
            end
         end else if (imem_req_o) begin
            pend = 1; wcnt = $urandom_range(1, 3);
         end
         stall_i  = ($urandom_range(0, 9) < 3);
         flush_i  = ($urandom_range(0, 99) < 8);
         target_i = $urandom;

         if (m_held && stall_i) m_stalls++;
         if (flush_i) begin
            if (m_kill) begin
               if (imem_ack_i) m_kill = 0;
            end else if (exp_req && !imem_ack_i) begin
               m_kill = 1;
            end
            m_held = 0;
            m_pc = target_i;
         end else if (m_kill) begin
            if (imem_ack_i) m_kill = 0;
         end else if (exp_req && imem_ack_i) begin
            m_held = 1; m_inst = imem_data_i; m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
         end else if (m_held && !stall_i) begin
            m_held = 0;
            m_fetches++;
         end
      end
      @(negedge clk);
      stall_i = 1; flush_i = 0; imem_ack_i = 0;
`ifdef FETCH_PERF_EN
      chk("perf_fetch", perf_fetch, 32'(m_fetches));
      chk("perf_stall", perf_stall, 32'(m_stalls));
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
